// File: rtl/alu_pkg.sv
// Shared state encoding, opcodes and operand-requirement helpers for alu_seq_core.
package alu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_EXEC = 3'd2,
    ST_MUL1 = 3'd3,
    ST_MUL2 = 3'd4
  } alu_state_e;

  // MODE=1 arithmetic opcodes
  localparam logic [3:0] AR_ADD     = 4'd0;
  localparam logic [3:0] AR_SUB     = 4'd1;
  localparam logic [3:0] AR_ADD_CIN = 4'd2;
  localparam logic [3:0] AR_SUB_CIN = 4'd3;
  localparam logic [3:0] AR_INC_A   = 4'd4;
  localparam logic [3:0] AR_DEC_A   = 4'd5;
  localparam logic [3:0] AR_INC_B   = 4'd6;
  localparam logic [3:0] AR_DEC_B   = 4'd7;
  localparam logic [3:0] AR_CMP     = 4'd8;
  localparam logic [3:0] AR_MUL_INC = 4'd9;
  localparam logic [3:0] AR_MUL_SHL = 4'd10;

  // MODE=0 logical opcodes
  localparam logic [3:0] LG_AND     = 4'd0;
  localparam logic [3:0] LG_NAND    = 4'd1;
  localparam logic [3:0] LG_OR      = 4'd2;
  localparam logic [3:0] LG_NOR     = 4'd3;
  localparam logic [3:0] LG_XOR     = 4'd4;
  localparam logic [3:0] LG_XNOR    = 4'd5;
  localparam logic [3:0] LG_NOT_A   = 4'd6;
  localparam logic [3:0] LG_NOT_B   = 4'd7;
  localparam logic [3:0] LG_SHR1_A  = 4'd8;
  localparam logic [3:0] LG_SHL1_A  = 4'd9;
  localparam logic [3:0] LG_SHR1_B  = 4'd10;
  localparam logic [3:0] LG_SHL1_B  = 4'd11;
  localparam logic [3:0] LG_ROL_A_B = 4'd12;
  localparam logic [3:0] LG_ROR_A_B = 4'd13;

  // Unary ops need a single operand; everything else, illegal codes included, needs both.
  function automatic logic needs_a(input logic mode, input logic [3:0] cmd);
    if (mode) return !(cmd == AR_INC_B || cmd == AR_DEC_B);
    return !(cmd == LG_NOT_B || cmd == LG_SHR1_B || cmd == LG_SHL1_B);
  endfunction

  function automatic logic needs_b(input logic mode, input logic [3:0] cmd);
    if (mode) return !(cmd == AR_INC_A || cmd == AR_DEC_A);
    return !(cmd == LG_NOT_A || cmd == LG_SHR1_A || cmd == LG_SHL1_A);
  endfunction

endpackage

// File: rtl/alu_seq_core_if.sv
// Command/operand/result bundle between the driver layer and alu_seq_core.
interface alu_seq_core_if #(
  parameter int WIDTH     = 8,
  parameter int CMD_WIDTH = 4
);
  // INP_VALID[0]/[1] qualify OPA/OPB on the sampling edge; there is no ready, so operands
  // offered while the core is busy are dropped. RES_VALID pulses for exactly one cycle when
  // RES and every flag update; outputs hold between pulses. CE=0 freezes the core.
  logic                 CE;
  logic                 MODE;
  logic [CMD_WIDTH-1:0] CMD;
  logic [1:0]           INP_VALID;
  logic [WIDTH-1:0]     OPA;
  logic [WIDTH-1:0]     OPB;
  logic                 CIN;
  logic [2*WIDTH:0]     RES;
  logic                 COUT;
  logic                 OFLOW;
  logic                 G;
  logic                 E;
  logic                 L;
  logic                 ERR;
  logic                 RES_VALID;

  modport master (
    output CE, MODE, CMD, INP_VALID, OPA, OPB, CIN,
    input  RES, COUT, OFLOW, G, E, L, ERR, RES_VALID
  );

  modport slave (
    input  CE, MODE, CMD, INP_VALID, OPA, OPB, CIN,
    output RES, COUT, OFLOW, G, E, L, ERR, RES_VALID
  );
endinterface

// File: rtl/alu_mul_pipe.sv
// Two-stage registered multiplier: stage 1 prepares (A+1,B+1) or (A<<1,B), stage 2 multiplies.
module alu_mul_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             shl_sel,
  output logic [2*WIDTH:0] prod
);
  localparam int RW = 2 * WIDTH + 1;
  localparam logic [RW-1:0] ONE = RW'(1);

  logic [RW-1:0] x_q;
  logic [RW-1:0] y_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      x_q  <= '0;
      y_q  <= '0;
      prod <= '0;
    end else if (en) begin
      x_q  <= shl_sel ? RW'({a, 1'b0}) : RW'(a) + ONE;
      y_q  <= shl_sel ? RW'(b) : RW'(b) + ONE;
      prod <= x_q * y_q;
    end
  end
endmodule

// File: rtl/alu_seq_core.sv
// Sequential ALU: multi-cycle operand collection with timeout, registered flags, RES_VALID strobe.
// Define ALU_MUL_EN to build the 3-cycle multiply path (MODE=1, CMD 9/10); otherwise those are illegal.
module alu_seq_core
  import alu_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int CMD_WIDTH = 4,
  parameter int TIMEOUT   = 16
) (
  input  logic               CLK,
  input  logic               RST,
  alu_seq_core_if.slave      bus,
  output alu_state_e         dbg_state
);
  localparam int RW = 2 * WIDTH + 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int AW = $clog2(WIDTH);
  localparam logic [TW-1:0]  T_LAST = TW'(TIMEOUT - 1);
  localparam logic [WIDTH:0] ONE_W  = (WIDTH + 1)'(1);

  alu_state_e           state;
  logic [WIDTH-1:0]     a_q, b_q;
  logic                 have_a, have_b;
  logic [CMD_WIDTH-1:0] cmd_q;
  logic                 mode_q, cin_q;
  logic [TW-1:0]        timer;
  logic [RW-1:0]        res_q;
  logic                 cout_q, oflow_q, g_q, e_q, l_q, err_q, rv_q;

  logic                 complete_idle, complete_wait;
  logic [RW-1:0]        r_res;
  logic                 r_cout, r_oflow, r_g, r_e, r_l, r_err, r_mul;
  logic [WIDTH:0]       sum, diff;
  logic [WIDTH-1:0]     lres;
  logic [2*WIDTH-1:0]   dbl;
  logic [AW-1:0]        rot_amt;
  logic                 rot_bad, cmd_hi_bad;
  logic [RW-1:0]        mul_prod;

  assign complete_idle = (!needs_a(bus.MODE, bus.CMD[3:0]) || bus.INP_VALID[0]) &&
                         (!needs_b(bus.MODE, bus.CMD[3:0]) || bus.INP_VALID[1]);
  assign complete_wait = (!needs_a(mode_q, cmd_q[3:0]) || have_a || bus.INP_VALID[0]) &&
                         (!needs_b(mode_q, cmd_q[3:0]) || have_b || bus.INP_VALID[1]);

  assign rot_amt    = b_q[AW-1:0];
  assign rot_bad    = (b_q >> AW) != '0;
  assign cmd_hi_bad = (cmd_q >> 4) != '0;

  always_comb begin
    r_res = '0; r_cout = 1'b0; r_oflow = 1'b0;
    r_g = 1'b0; r_e = 1'b0; r_l = 1'b0; r_err = 1'b0; r_mul = 1'b0;
    sum = '0; diff = '0; lres = '0; dbl = '0;
    if (cmd_hi_bad) begin
      r_err = 1'b1;
    end else if (mode_q) begin
      case (cmd_q[3:0])
        AR_ADD:     begin sum  = {1'b0, a_q} + {1'b0, b_q};                  r_res = RW'(sum); r_cout = sum[WIDTH]; end
        AR_ADD_CIN: begin sum  = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, cin_q};
                          r_res = RW'(sum); r_cout = sum[WIDTH]; end
        AR_INC_A:   begin sum  = {1'b0, a_q} + ONE_W;                        r_res = RW'(sum); r_cout = sum[WIDTH]; end
        AR_INC_B:   begin sum  = {1'b0, b_q} + ONE_W;                        r_res = RW'(sum); r_cout = sum[WIDTH]; end
        // Bit WIDTH of the widened difference is the borrow.
        AR_SUB:     begin diff = {1'b0, a_q} - {1'b0, b_q};     r_res = RW'(diff[WIDTH-1:0]); r_oflow = diff[WIDTH]; end
        AR_SUB_CIN: begin diff = {1'b0, a_q} - {1'b0, b_q} - {{WIDTH{1'b0}}, cin_q};
                          r_res = RW'(diff[WIDTH-1:0]); r_oflow = diff[WIDTH]; end
        AR_DEC_A:   begin diff = {1'b0, a_q} - ONE_W;           r_res = RW'(diff[WIDTH-1:0]); r_oflow = diff[WIDTH]; end
        AR_DEC_B:   begin diff = {1'b0, b_q} - ONE_W;           r_res = RW'(diff[WIDTH-1:0]); r_oflow = diff[WIDTH]; end
        AR_CMP:     begin r_g = a_q > b_q; r_e = a_q == b_q; r_l = a_q < b_q; end
`ifdef ALU_MUL_EN
        AR_MUL_INC, AR_MUL_SHL: r_mul = 1'b1;
`endif
        default:    r_err = 1'b1;
      endcase
    end else begin
      case (cmd_q[3:0])
        LG_AND:     lres = a_q & b_q;
        LG_NAND:    lres = ~(a_q & b_q);
        LG_OR:      lres = a_q | b_q;
        LG_NOR:     lres = ~(a_q | b_q);
        LG_XOR:     lres = a_q ^ b_q;
        LG_XNOR:    lres = ~(a_q ^ b_q);
        LG_NOT_A:   lres = ~a_q;
        LG_NOT_B:   lres = ~b_q;
        LG_SHR1_A:  lres = a_q >> 1;
        LG_SHL1_A:  lres = a_q << 1;
        LG_SHR1_B:  lres = b_q >> 1;
        LG_SHL1_B:  lres = b_q << 1;
        // Rotates still drive their result when the amount is out of range; only ERR flags it.
        LG_ROL_A_B: begin dbl = {a_q, a_q} << rot_amt; lres = dbl[2*WIDTH-1:WIDTH]; r_err = rot_bad; end
        LG_ROR_A_B: begin dbl = {a_q, a_q} >> rot_amt; lres = dbl[WIDTH-1:0];       r_err = rot_bad; end
        default:    r_err = 1'b1;
      endcase
      r_res = RW'(lres);
    end
  end

`ifdef ALU_MUL_EN
  alu_mul_pipe #(.WIDTH(WIDTH)) u_mul (
    .CLK     (CLK),
    .RST     (RST),
    .en      (bus.CE),
    .a       (a_q),
    .b       (b_q),
    .shl_sel (cmd_q[3:0] == AR_MUL_SHL),
    .prod    (mul_prod)
  );
`else
  assign mul_prod = '0;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= ST_IDLE; a_q <= '0; b_q <= '0; have_a <= 1'b0; have_b <= 1'b0;
      cmd_q <= '0; mode_q <= 1'b0; cin_q <= 1'b0; timer <= '0;
      res_q <= '0; cout_q <= 1'b0; oflow_q <= 1'b0; g_q <= 1'b0; e_q <= 1'b0; l_q <= 1'b0;
      err_q <= 1'b0; rv_q <= 1'b0;
    end else if (!bus.CE) begin
      rv_q <= 1'b0;
    end else begin
      rv_q <= 1'b0;
      case (state)
        ST_IDLE: if (bus.INP_VALID != 2'b00) begin
          cmd_q  <= bus.CMD; mode_q <= bus.MODE; cin_q <= bus.CIN;
          if (bus.INP_VALID[0]) a_q <= bus.OPA;
          if (bus.INP_VALID[1]) b_q <= bus.OPB;
          have_a <= bus.INP_VALID[0];
          have_b <= bus.INP_VALID[1];
          timer  <= '0;
          state  <= complete_idle ? ST_EXEC : ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.INP_VALID[0] && !have_a) begin a_q <= bus.OPA; have_a <= 1'b1; end
          if (bus.INP_VALID[1] && !have_b) begin b_q <= bus.OPB; have_b <= 1'b1; end
          // A completing operand on the last timer cycle takes priority over the timeout.
          if (complete_wait) begin
            state <= ST_EXEC;
          end else if (timer == T_LAST) begin
            res_q <= '0; cout_q <= 1'b0; oflow_q <= 1'b0; g_q <= 1'b0; e_q <= 1'b0; l_q <= 1'b0;
            err_q <= 1'b1; rv_q <= 1'b1; state <= ST_IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_EXEC: if (r_mul) begin
          state <= ST_MUL1;
        end else begin
          res_q <= r_res; cout_q <= r_cout; oflow_q <= r_oflow;
          g_q <= r_g; e_q <= r_e; l_q <= r_l; err_q <= r_err; rv_q <= 1'b1; state <= ST_IDLE;
        end
`ifdef ALU_MUL_EN
        ST_MUL1: state <= ST_MUL2;
        ST_MUL2: begin
          res_q <= mul_prod; cout_q <= 1'b0; oflow_q <= 1'b0;
          g_q <= 1'b0; e_q <= 1'b0; l_q <= 1'b0; err_q <= 1'b0; rv_q <= 1'b1; state <= ST_IDLE;
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.RES       = res_q;
  assign bus.COUT      = cout_q;
  assign bus.OFLOW     = oflow_q;
  assign bus.G         = g_q;
  assign bus.E         = e_q;
  assign bus.L         = l_q;
  assign bus.ERR       = err_q;
  assign bus.RES_VALID = rv_q;
  assign dbg_state     = state;
endmodule

// File: tb/tb_alu_seq_core.sv
// Directed self-checking bench for alu_seq_core; expectations follow ALU_MUL_EN when it is defined.
module tb_alu_seq_core;
  import alu_pkg::*;

  localparam int WIDTH     = 8;
  localparam int CMD_WIDTH = 4;
  localparam int TIMEOUT   = 16;

  logic       CLK;
  logic       RST;
  alu_state_e dbg_state;

  alu_seq_core_if #(.WIDTH(WIDTH), .CMD_WIDTH(CMD_WIDTH)) bus ();

  alu_seq_core #(.WIDTH(WIDTH), .CMD_WIDTH(CMD_WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  // scoreboard
  logic [2*WIDTH:0] exp_q[$];
  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp)
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    else
      n_pass++;
  endtask

  // driver tasks
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic mode, input logic [3:0] cmd, input logic [1:0] vld,
                       input logic [7:0] a, input logic [7:0] b, input logic cin);
    bus.MODE = mode; bus.CMD = cmd; bus.INP_VALID = vld;
    bus.OPA = a; bus.OPB = b; bus.CIN = cin;
  endtask

  task automatic idle_inputs();
    bus.INP_VALID = 2'b00;
    bus.OPA = 8'($urandom_range(0, 255));
    bus.OPB = 8'($urandom_range(0, 255));
  endtask

  task automatic wait_result(input int max_cyc, output int lat);
    lat = 0;
    do begin
      step();
      lat++;
    end while (!bus.RES_VALID && lat < max_cyc);
    if (!bus.RES_VALID) lat = -1;
  endtask

  task automatic do_op(input string tag, input logic mode, input logic [3:0] cmd,
                       input logic [1:0] vld, input logic [7:0] a, input logic [7:0] b,
                       input logic cin, input logic [2*WIDTH:0] exp_res, input int exp_lat);
    int lat;
    exp_q.push_back(exp_res);
    drive(mode, cmd, vld, a, b, cin);
    step();
    idle_inputs();
    wait_result(8, lat);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_res"}, 32'(bus.RES), 32'(exp_q.pop_front()));
  endtask

  initial begin
    int lat;
    logic rv_seen;

    RST = 1'b0;
    bus.CE = 1'b1;
    drive(1'b0, 4'd0, 2'b00, 8'd0, 8'd0, 1'b0);
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b1;

    check("rst_res",   32'(bus.RES), 32'd0);
    check("rst_rv",    32'(bus.RES_VALID), 32'd0);
    check("rst_flags", 32'({bus.COUT, bus.OFLOW, bus.G, bus.E, bus.L, bus.ERR}), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));

    // INP_VALID=00 leaves the core idle
    step();
    check("idle_stay", 32'(dbg_state), 32'(ST_IDLE));

    do_op("add", 1'b1, AR_ADD, 2'b11, 8'd200, 8'd100, 1'b0, 17'd300, 1);
    check("add_cout", 32'(bus.COUT), 32'd1);
    check("add_err",  32'(bus.ERR), 32'd0);
    step();
    check("add_rv_drop", 32'(bus.RES_VALID), 32'd0);
    check("add_hold",    32'(bus.RES), 32'd300);

    // split operands; CMD change while waiting must be ignored, as must OPA with only OPB valid
    drive(1'b1, AR_SUB, 2'b01, 8'd5, 8'd0, 1'b0);
    step();
    idle_inputs();
    check("split_state", 32'(dbg_state), 32'(ST_WAIT));
    step();
    step();
    drive(1'b1, AR_ADD, 2'b10, 8'd99, 8'd3, 1'b0);
    step();
    idle_inputs();
    wait_result(8, lat);
    check("split_lat",   32'(lat), 32'd1);
    check("split_res",   32'(bus.RES), 32'd2);
    check("split_oflow", 32'(bus.OFLOW), 32'd0);

    // timeout with only OPA
    drive(1'b1, AR_ADD, 2'b01, 8'd7, 8'd0, 1'b0);
    step();
    idle_inputs();
    wait_result(TIMEOUT + 4, lat);
    check("to_lat", 32'(lat), 32'(TIMEOUT));
    check("to_err", 32'(bus.ERR), 32'd1);
    check("to_res", 32'(bus.RES), 32'd0);
    step();
    check("to_idle", 32'(dbg_state), 32'(ST_IDLE));

    // OPB arriving on the timeout cycle wins
    drive(1'b1, AR_ADD, 2'b01, 8'd10, 8'd0, 1'b0);
    step();
    idle_inputs();
    rv_seen = 1'b0;
    repeat (TIMEOUT - 1) begin
      step();
      rv_seen |= bus.RES_VALID;
    end
    check("late_quiet", 32'(rv_seen), 32'd0);
    drive(1'b1, AR_ADD, 2'b10, 8'd0, 8'd20, 1'b0);
    step();
    idle_inputs();
    check("late_no_to", 32'(bus.RES_VALID), 32'd0);
    wait_result(4, lat);
    check("late_lat", 32'(lat), 32'd1);
    check("late_res", 32'(bus.RES), 32'd30);
    check("late_err", 32'(bus.ERR), 32'd0);

`ifdef ALU_MUL_EN
    do_op("mul_inc", 1'b1, AR_MUL_INC, 2'b11, 8'd15, 8'd15, 1'b0, 17'd256, 3);
    check("mul_inc_err", 32'(bus.ERR), 32'd0);
    do_op("mul_shl", 1'b1, AR_MUL_SHL, 2'b11, 8'd3, 8'd5, 1'b0, 17'd30, 3);
`else
    do_op("mul_inc", 1'b1, AR_MUL_INC, 2'b11, 8'd15, 8'd15, 1'b0, 17'd0, 1);
    check("mul_inc_err", 32'(bus.ERR), 32'd1);
    do_op("mul_shl", 1'b1, AR_MUL_SHL, 2'b11, 8'd3, 8'd5, 1'b0, 17'd0, 1);
`endif

    do_op("rol_bad", 1'b0, LG_ROL_A_B, 2'b11, 8'h81, 8'h09, 1'b0, 17'h03, 1);
    check("rol_bad_err", 32'(bus.ERR), 32'd1);
    do_op("ror", 1'b0, LG_ROR_A_B, 2'b11, 8'h81, 8'h01, 1'b0, 17'hC0, 1);
    check("ror_err", 32'(bus.ERR), 32'd0);

    do_op("cmp", 1'b1, AR_CMP, 2'b11, 8'd5, 8'd9, 1'b0, 17'd0, 1);
    check("cmp_gel", 32'({bus.G, bus.E, bus.L}), 32'b001);
    do_op("cmp_eq", 1'b1, AR_CMP, 2'b11, 8'd42, 8'd42, 1'b0, 17'd0, 1);
    check("cmp_eq_gel", 32'({bus.G, bus.E, bus.L}), 32'b010);

    do_op("sub_brw", 1'b1, AR_SUB, 2'b11, 8'd3, 8'd5, 1'b0, 17'd254, 1);
    check("sub_brw_oflow", 32'(bus.OFLOW), 32'd1);
    do_op("subc", 1'b1, AR_SUB_CIN, 2'b11, 8'd5, 8'd5, 1'b1, 17'd255, 1);
    check("subc_oflow", 32'(bus.OFLOW), 32'd1);
    do_op("addc", 1'b1, AR_ADD_CIN, 2'b11, 8'd255, 8'd255, 1'b1, 17'd511, 1);
    check("addc_cout", 32'(bus.COUT), 32'd1);
    check("addc_gel",  32'({bus.G, bus.E, bus.L}), 32'd0);
    do_op("inc_a", 1'b1, AR_INC_A, 2'b01, 8'd255, 8'd0, 1'b0, 17'd256, 1);
    do_op("dec_b", 1'b1, AR_DEC_B, 2'b10, 8'd0, 8'd1, 1'b0, 17'd0, 1);
    check("dec_b_oflow", 32'(bus.OFLOW), 32'd0);
    do_op("nand", 1'b0, LG_NAND, 2'b11, 8'hF0, 8'h3C, 1'b0, 17'hCF, 1);
    do_op("shr_b", 1'b0, LG_SHR1_B, 2'b10, 8'h00, 8'h81, 1'b0, 17'h40, 1);
    do_op("illegal", 1'b0, 4'd14, 2'b11, 8'h12, 8'h34, 1'b0, 17'd0, 1);
    check("illegal_err", 32'(bus.ERR), 32'd1);

    // CE=0 freezes the core in EXEC and suppresses RES_VALID
    drive(1'b1, AR_ADD, 2'b11, 8'd1, 8'd2, 1'b0);
    step();
    idle_inputs();
    bus.CE = 1'b0;
    repeat (2) begin
      step();
      check("ce_rv",    32'(bus.RES_VALID), 32'd0);
      check("ce_state", 32'(dbg_state), 32'(ST_EXEC));
    end
    bus.CE = 1'b1;
    wait_result(4, lat);
    check("ce_lat", 32'(lat), 32'd1);
    check("ce_res", 32'(bus.RES), 32'd3);

    // reset during the multiply pipeline aborts silently
    do_op("pre_rst", 1'b0, LG_NAND, 2'b11, 8'hF0, 8'h3C, 1'b0, 17'hCF, 1);
    drive(1'b1, AR_MUL_INC, 2'b11, 8'd15, 8'd15, 1'b0);
    step();
    idle_inputs();
    step();
    RST = 1'b0;
    #1;
    check("mrst_res",   32'(bus.RES), 32'd0);
    check("mrst_rv",    32'(bus.RES_VALID), 32'd0);
    check("mrst_flags", 32'({bus.COUT, bus.OFLOW, bus.G, bus.E, bus.L, bus.ERR}), 32'd0);
    check("mrst_state", 32'(dbg_state), 32'(ST_IDLE));
    step();
    step();
    RST = 1'b1;
    rv_seen = 1'b0;
    repeat (4) begin
      step();
      rv_seen |= bus.RES_VALID;
    end
    check("mrst_quiet", 32'(rv_seen), 32'd0);
    do_op("post_rst", 1'b1, AR_ADD, 2'b11, 8'd10, 8'd20, 1'b0, 17'd30, 1);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
